// File: rtl/misr_response_analyzer.sv
// misr_response_analyzer
//   Output-response analyzer for the BIST chain. Compacts one CUT response
//   word per enabled clock into a Galois MISR over PATTERNS words, then
//   compares the final signature against a golden value.
//
// Ports
//   clock      rising-edge system clock
//   rst        asynchronous reset, active low
//   start      session start pulse (seeds the MISR, clears count)
//   abort      cancel session, back to IDLE; wins over start
//   en         qualifies resp; one word compacted per cycle with en=1
//   poly       MISR feedback polynomial
//   seed       initial signature, loaded on start
//   resp       CUT response word
//   golden     expected final signature, sampled in COMPARE
//   signature  current MISR contents
//   count      responses compacted in this session
//   busy       high in COMPACT and COMPARE
//   done       high in DONE
//   pass       signature==golden, meaningful only while done=1
module misr_response_analyzer #(
  parameter int WIDTH    = 8,
  parameter int PATTERNS = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic [WIDTH-1:0] poly,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] resp,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sig_nxt;
  logic             load, shift;

  // Galois MISR step: shift toward MSB, fold poly back in when MSB falls out
  always_comb begin
    sig_nxt = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? poly : '0) ^ resp;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          load      = 1'b1;
          state_nxt = COMPACT;
        end
        COMPACT: if (en) begin
          shift = 1'b1;
          if (count == LAST) state_nxt = COMPARE;
        end
        COMPARE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // busy/done are registered copies of the next state so outputs carry no
  // combinational path from inputs. signature/count are left untouched on
  // abort so the partial result stays visible for debug.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      signature <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (load) begin
        signature <= seed;
        count     <= '0;
      end else if (shift) begin
        signature <= sig_nxt;
        count     <= count + CNT_W'(1);
      end
      busy <= (state_nxt == COMPACT) || (state_nxt == COMPARE);
      done <= (state_nxt == DONE);
      if (abort || load)          pass <= 1'b0;
      else if (state == COMPARE)  pass <= (signature == golden);
    end
  end

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Bench for misr_response_analyzer. Three instances share the input bus
// (PATTERNS = 8, 2, 1); each scenario targets one of them. Expected final
// results are pushed to a scoreboard queue when a session is set up and
// popped when the targeted instance raises done.
module tb_misr_response_analyzer;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0, abort = 1'b0, en = 1'b0;
  logic [7:0] poly = '0, seed = '0, resp = '0, golden = '0;

  logic [7:0] sig8, sig2, sig1;
  logic [3:0] cnt8;
  logic [1:0] cnt2;
  logic [0:0] cnt1;
  logic       busy8, done8, pass8;
  logic       busy2, done2, pass2;
  logic       busy1, done1, pass1;

  misr_response_analyzer #(.WIDTH(8), .PATTERNS(8), .CNT_W(4)) d8 (
    .clock(clock), .rst(rst), .start(start), .abort(abort), .en(en), .poly(poly),
    .seed(seed), .resp(resp), .golden(golden), .signature(sig8), .count(cnt8),
    .busy(busy8), .done(done8), .pass(pass8));
  misr_response_analyzer #(.WIDTH(8), .PATTERNS(2), .CNT_W(2)) d2 (
    .clock(clock), .rst(rst), .start(start), .abort(abort), .en(en), .poly(poly),
    .seed(seed), .resp(resp), .golden(golden), .signature(sig2), .count(cnt2),
    .busy(busy2), .done(done2), .pass(pass2));
  misr_response_analyzer #(.WIDTH(8), .PATTERNS(1), .CNT_W(1)) d1 (
    .clock(clock), .rst(rst), .start(start), .abort(abort), .en(en), .poly(poly),
    .seed(seed), .resp(resp), .golden(golden), .signature(sig1), .count(cnt1),
    .busy(busy1), .done(done1), .pass(pass1));

  always #5 clock = ~clock;

  typedef struct { logic [7:0] sig; logic pass; } exp_t;
  exp_t sb[$];
  exp_t e;

  int tests = 0, fails = 0;
  logic [7:0] words [8];
  bit ok;

  function automatic logic [7:0] misr_model(logic [7:0] s, logic [7:0] r, logic [7:0] p);
    return {s[6:0], 1'b0} ^ (s[7] ? p : 8'h00) ^ r;
  endfunction

  function automatic logic [7:0] lfsr_model(logic [7:0] s, logic [7:0] p);
    return {s[6:0], 1'b0} ^ (s[7] ? p : 8'h00);
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_all();
    en = 0; start = 0; abort = 1; step(); abort = 0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  // expected signature of a gap-free run over words[0..7]
  function automatic logic [7:0] model_run(logic [7:0] s, logic [7:0] p);
    for (int i = 0; i < 8; i++) s = misr_model(s, words[i], p);
    return s;
  endfunction

  task automatic feed_words();
    for (int i = 0; i < 8; i++) begin en = 1; resp = words[i]; step(); end
    en = 0;
  endtask

  task automatic wait_done(input int which, output bit hit);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if ((which == 8 && done8) || (which == 2 && done2) || (which == 1 && done1)) begin
        hit = 1; break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    tests++; if (sig8 !== 8'h00 || cnt8 !== 4'd0) begin fails++; $display("FAIL reset_init sig=%h cnt=%0d want 00/0", sig8, cnt8); end
    tests++; if ({busy8, done8, pass8} !== 3'b000) begin fails++; $display("FAIL reset_init_flags got %b want 000", {busy8, done8, pass8}); end
    @(negedge clock); rst = 1; step();
    poly = 8'h1D; seed = 8'h5A; pulse_start();
    en = 1; resp = 8'h33; step(); step(); step(); en = 0;
    #2 rst = 0; #1;
    tests++; if (sig8 !== 8'h00 || cnt8 !== 4'd0) begin fails++; $display("FAIL reset_async sig=%h cnt=%0d want 00/0", sig8, cnt8); end
    tests++; if ({busy8, done8, pass8} !== 3'b000) begin fails++; $display("FAIL reset_async_flags got %b want 000", {busy8, done8, pass8}); end
    #4 rst = 1; step();
  endtask

  task automatic test_basic();
    idle_all();
    poly = 8'h1D; seed = 8'h00; golden = 8'h00;
    sb.push_back('{sig: 8'h00, pass: 1'b1});
    pulse_start();
    en = 1; resp = 8'h01; step();
    tests++; if (sig2 !== 8'h01 || cnt2 !== 2'd1) begin fails++; $display("FAIL basic_w1 sig=%h cnt=%0d want 01/1", sig2, cnt2); end
    resp = 8'h02; step(); en = 0;
    tests++; if (sig2 !== 8'h00 || busy2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("FAIL basic_w2 sig=%h busy=%b done=%b want 00/1/0", sig2, busy2, done2); end
    step();
    tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL basic_done_latency done=%b want 1", done2); end
    e = sb.pop_front();
    tests++; if (sig2 !== e.sig || pass2 !== e.pass) begin fails++; $display("FAIL basic_result sig=%h pass=%b want %h/%b", sig2, pass2, e.sig, e.pass); end
  endtask

  task automatic test_feedback();
    idle_all();
    poly = 8'h1D; seed = 8'h80; resp = 8'h00;
    for (int k = 0; k < 2; k++) begin
      golden = (k == 0) ? 8'h1D : 8'h1C;
      sb.push_back('{sig: 8'h1D, pass: (k == 0)});
      pulse_start();
      en = 1; step(); en = 0;
      wait_done(1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL feedback_done%0d timeout done=%b want 1", k, done1); end
      e = sb.pop_front();
      tests++; if (sig1 !== e.sig || pass1 !== e.pass) begin fails++; $display("FAIL feedback_result%0d sig=%h pass=%b want %h/%b", k, sig1, pass1, e.sig, e.pass); end
    end
  endtask

  task automatic test_stalls();
    logic [7:0] exp_sig;
    idle_all();
    poly = 8'h8E; seed = 8'h3C;
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    exp_sig = model_run(seed, poly);
    golden = exp_sig;
    sb.push_back('{sig: exp_sig, pass: 1'b1});
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      en = 1; resp = words[i]; step();
      tests++; if (cnt8 !== 4'(i + 1)) begin fails++; $display("FAIL stall_count%0d got %0d want %0d", i, cnt8, i + 1); end
      if (i < 7) begin
        en = 0; resp = 8'($urandom); start = (i == 2); step(); start = 0; step();
        tests++; if (cnt8 !== 4'(i + 1) || busy8 !== 1'b1) begin fails++; $display("FAIL stall_hold%0d cnt=%0d busy=%b want %0d/1", i, cnt8, busy8, i + 1); end
      end
    end
    en = 0;
    wait_done(8, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_done timeout done=%b want 1", done8); end
    e = sb.pop_front();
    tests++; if (sig8 !== e.sig || pass8 !== e.pass) begin fails++; $display("FAIL stall_result sig=%h pass=%b want %h/%b", sig8, pass8, e.sig, e.pass); end
  endtask

  task automatic test_abort();
    idle_all();
    poly = 8'h1D; seed = 8'h11;
    pulse_start();
    en = 1; resp = 8'h42; step(); step(); step(); en = 0;
    tests++; if (cnt8 !== 4'd3) begin fails++; $display("FAIL abort_pre cnt=%0d want 3", cnt8); end
    abort = 1; step(); abort = 0;
    tests++; if (busy8 !== 1'b0 || done8 !== 1'b0 || cnt8 !== 4'd3) begin fails++; $display("FAIL abort_idle busy=%b done=%b cnt=%0d want 0/0/3", busy8, done8, cnt8); end
    seed = 8'h77; start = 1; abort = 1; step(); start = 0; abort = 0;
    tests++; if (busy8 !== 1'b0 || cnt8 !== 4'd3) begin fails++; $display("FAIL abort_wins busy=%b cnt=%0d want 0/3", busy8, cnt8); end
    pulse_start();
    tests++; if (sig8 !== 8'h77 || cnt8 !== 4'd0 || busy8 !== 1'b1) begin fails++; $display("FAIL abort_restart sig=%h cnt=%0d busy=%b want 77/0/1", sig8, cnt8, busy8); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_sig;
    idle_all();
    poly = 8'h1D; seed = 8'hA5;
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    exp_sig = model_run(seed, poly); golden = exp_sig;
    sb.push_back('{sig: exp_sig, pass: 1'b1});
    pulse_start(); feed_words();
    wait_done(8, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_done1 timeout done=%b want 1", done8); end
    e = sb.pop_front();
    tests++; if (sig8 !== e.sig || pass8 !== e.pass) begin fails++; $display("FAIL b2b_result1 sig=%h pass=%b want %h/%b", sig8, pass8, e.sig, e.pass); end
    seed = 8'h5A;
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    exp_sig = model_run(seed, poly); golden = exp_sig ^ 8'h01;
    sb.push_back('{sig: exp_sig, pass: 1'b0});
    pulse_start();
    tests++; if (done8 !== 1'b0 || pass8 !== 1'b0 || sig8 !== 8'h5A) begin fails++; $display("FAIL b2b_restart done=%b pass=%b sig=%h want 0/0/5a", done8, pass8, sig8); end
    feed_words();
    wait_done(8, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_done2 timeout done=%b want 1", done8); end
    e = sb.pop_front();
    tests++; if (sig8 !== e.sig || pass8 !== e.pass) begin fails++; $display("FAIL b2b_result2 sig=%h pass=%b want %h/%b", sig8, pass8, e.sig, e.pass); end
  endtask

  task automatic test_integration();
    logic [7:0] l, good;
    for (int k = 0; k < 2; k++) begin
      idle_all();
      l = 8'h01;
      for (int i = 0; i < 8; i++) begin words[i] = l; l = lfsr_model(l, 8'h1D); end
      poly = 8'hB8; seed = 8'hFF;
      good = model_run(seed, poly); golden = good;
      if (k == 1) words[4] = words[4] ^ 8'h10;
      sb.push_back('{sig: model_run(seed, poly), pass: (k == 0)});
      pulse_start(); feed_words();
      wait_done(8, ok);
      tests++; if (!ok) begin fails++; $display("FAIL integ_done%0d timeout done=%b want 1", k, done8); end
      e = sb.pop_front();
      tests++; if (sig8 !== e.sig || pass8 !== e.pass) begin fails++; $display("FAIL integ_result%0d sig=%h pass=%b want %h/%b", k, sig8, pass8, e.sig, e.pass); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_feedback();
    test_stalls();
    test_abort();
    test_back_to_back();
    test_integration();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
